// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard control: load-use bubble, branch flush, data-memory freeze with timeout.
// Optional stall performance counters are enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_MemRead,
    input  logic [4:0] ex_rd,
    input  logic       id_branch_taken,
    input  logic       mem_req,
    input  logic       dmem_ack,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       mem_wb_bubble,
`ifdef HAZ_PERF_CNT_EN
    output logic [15:0] lu_stall_cnt,
    output logic [15:0] mem_stall_cnt,
`endif
    output logic       mem_err
);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    state_t     state, state_n;
    logic [7:0] wcnt, wcnt_n;
    logic       mem_err_q;
    logic       err_set;
    logic       freeze;
    logic       load_use;

    assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wcnt      <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (err_set)
                mem_err_q <= 1'b1;
        end
    end

    // Next state; freeze selects the memory-stall output set, otherwise the RUN rules apply.
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        err_set = 1'b0;
        freeze  = 1'b0;
        if (rst) begin
            state_n = RUN;
            wcnt_n  = 8'd0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !dmem_ack) begin
                        freeze  = 1'b1;
                        state_n = MEM_WAIT;
                        wcnt_n  = 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        state_n = RUN;
                        wcnt_n  = 8'd0;
                    end else if (wcnt == 8'hFF) begin
                        // Abandon the access: flag the timeout and let the pipeline move on.
                        err_set = 1'b1;
                        state_n = RUN;
                        wcnt_n  = 8'd0;
                    end else begin
                        freeze = 1'b1;
                        wcnt_n = wcnt + 8'd1;
                    end
                end
                default: begin
                    state_n = RUN;
                    wcnt_n  = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (freeze) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else begin
            if_id_flush = id_branch_taken;
        end
    end

    assign mem_err = mem_err_q && !rst;

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_stall_cnt  <= 16'd0;
            mem_stall_cnt <= 16'd0;
        end else begin
            if (!freeze && load_use && (lu_stall_cnt != 16'hFFFF))
                lu_stall_cnt <= lu_stall_cnt + 16'd1;
            if (freeze && (mem_stall_cnt != 16'hFFFF))
                mem_stall_cnt <= mem_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl (HAZ_PERF_CNT_EN optional).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       ex_MemRead, id_branch_taken, mem_req, dmem_ack;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic       if_id_flush, id_ex_flush, mem_wb_bubble, mem_err;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] lu_stall_cnt, mem_stall_cnt;
    logic [15:0] cnt_base;
`endif

    int total = 0;
    int bad   = 0;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble, mem_err}
    localparam logic [7:0] E_RUN = 8'b1111_0000;
    localparam logic [7:0] E_LU  = 8'b0011_0100;
    localparam logic [7:0] E_BR  = 8'b1111_1000;
    localparam logic [7:0] E_FRZ = 8'b0000_0010;
    localparam logic [7:0] E_RST = 8'b0000_1110;
    localparam logic [7:0] E_ERR = 8'b0000_0001;

    logic [7:0] exp_q[$];
    logic [7:0] obs, exp_v;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .id_branch_taken(id_branch_taken),
        .mem_req(mem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble),
`ifdef HAZ_PERF_CNT_EN
        .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt),
`endif
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble, mem_err};

    task automatic drive(input logic r, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic br, input logic mq, input logic ack);
        rst = r; ex_MemRead = mr; ex_rd = rd; id_rs = rs; id_rt = rt;
        id_branch_taken = br; mem_req = mq; dmem_ack = ack;
    endtask

    task automatic advance;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(E_RST);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_out got=%b want=%b", obs, exp_v); end
        advance();
        exp_q.push_back(E_RST);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_hold got=%b want=%b", obs, exp_v); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(E_RUN);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL idle_run got=%b want=%b", obs, exp_v); end
        advance();
    endtask

    task automatic test_load_use;
`ifdef HAZ_PERF_CNT_EN
        cnt_base = lu_stall_cnt;
`endif
        drive(0, 1, 8, 8, 3, 0, 0, 0);
        exp_q.push_back(E_LU);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL lu_rs got=%b want=%b", obs, exp_v); end
        advance();
        drive(0, 0, 0, 8, 3, 0, 0, 0);
        exp_q.push_back(E_RUN);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL lu_after got=%b want=%b", obs, exp_v); end
        advance();
        // rt match with a taken branch: branch must be ignored
        drive(0, 1, 17, 4, 17, 1, 0, 0);
        exp_q.push_back(E_LU);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL lu_rt_branch got=%b want=%b", obs, exp_v); end
        advance();
        drive(0, 0, 17, 4, 17, 0, 0, 0);
        exp_q.push_back(E_RUN);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL non_load_match got=%b want=%b", obs, exp_v); end
        advance();
`ifdef HAZ_PERF_CNT_EN
        total++;
        if (lu_stall_cnt !== cnt_base + 16'd2) begin
            bad++; $display("FAIL lu_stall_cnt got=%0d want=%0d", lu_stall_cnt, cnt_base + 16'd2);
        end
`endif
    endtask

    task automatic test_rd_zero;
        drive(0, 1, 0, 5, 0, 0, 0, 0);
        exp_q.push_back(E_RUN);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rd_zero got=%b want=%b", obs, exp_v); end
        advance();
    endtask

    task automatic test_branch;
        drive(0, 0, 0, 1, 2, 1, 0, 0);
        exp_q.push_back(E_BR);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL branch got=%b want=%b", obs, exp_v); end
        advance();
        drive(0, 0, 0, 1, 2, 0, 0, 0);
        exp_q.push_back(E_RUN);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL branch_after got=%b want=%b", obs, exp_v); end
        advance();
    endtask

    task automatic test_mem_ack_same;
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        exp_q.push_back(E_RUN);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL mem_ack_same got=%b want=%b", obs, exp_v); end
        advance();
    endtask

    task automatic test_mem_wait;
`ifdef HAZ_PERF_CNT_EN
        cnt_base = mem_stall_cnt;
`endif
        // load-use and branch present throughout: freeze must win, flushes stay 0
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 9, 9, 0, 1, 1, 0);
            exp_q.push_back(E_FRZ);
            @(negedge clk);
            exp_v = exp_q.pop_front(); total++;
            if (obs !== exp_v) begin bad++; $display("FAIL mem_wait_%0d got=%b want=%b", i, obs, exp_v); end
            advance();
        end
        drive(0, 0, 0, 0, 0, 1, 1, 1);
        exp_q.push_back(E_BR);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL mem_release got=%b want=%b", obs, exp_v); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(E_RUN);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL mem_after got=%b want=%b", obs, exp_v); end
        advance();
`ifdef HAZ_PERF_CNT_EN
        total++;
        if (mem_stall_cnt !== cnt_base + 16'd3) begin
            bad++; $display("FAIL mem_stall_cnt got=%0d want=%0d", mem_stall_cnt, cnt_base + 16'd3);
        end
`endif
    endtask

    task automatic test_timeout;
        int frz_bad = 0;
        for (int i = 0; i < 255; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            exp_q.push_back(E_FRZ);
            @(negedge clk);
            exp_v = exp_q.pop_front(); total++;
            if (obs !== exp_v) begin
                bad++; frz_bad++;
                if (frz_bad < 4) $display("FAIL timeout_frz_%0d got=%b want=%b", i, obs, exp_v);
            end
            advance();
        end
        exp_q.push_back(E_RUN);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL timeout_release got=%b want=%b", obs, exp_v); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(E_RUN | E_ERR);
            @(negedge clk);
            exp_v = exp_q.pop_front(); total++;
            if (obs !== exp_v) begin bad++; $display("FAIL err_sticky_%0d got=%b want=%b", i, obs, exp_v); end
            advance();
        end
        total++;
        if (dut.state !== 1'b0) begin bad++; $display("FAIL timeout_state got=%b want=0", dut.state); end
    endtask

    task automatic test_reset_mid_wait;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            exp_q.push_back(E_FRZ | E_ERR);
            @(negedge clk);
            exp_v = exp_q.pop_front(); total++;
            if (obs !== exp_v) begin bad++; $display("FAIL pre_rst_frz_%0d got=%b want=%b", i, obs, exp_v); end
            advance();
        end
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        exp_q.push_back(E_RST);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rst_in_wait got=%b want=%b", obs, exp_v); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(E_RUN);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL post_rst got=%b want=%b", obs, exp_v); end
        total++;
        if (dut.wcnt !== 8'd0) begin bad++; $display("FAIL post_rst_wcnt got=%0d want=0", dut.wcnt); end
        total++;
        if (dut.state !== 1'b0) begin bad++; $display("FAIL post_rst_state got=%b want=0", dut.state); end
`ifdef HAZ_PERF_CNT_EN
        total++;
        if (mem_stall_cnt !== 16'd0 || lu_stall_cnt !== 16'd0) begin
            bad++; $display("FAIL post_rst_cnt got=%0d/%0d want=0/0", lu_stall_cnt, mem_stall_cnt);
        end
`endif
        advance();
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_load_use();
        test_rd_zero();
        test_branch();
        test_mem_ack_same();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL queue_left got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
